// File: rtl/cpx_conj_mac.sv
// Conjugate multiply-accumulate: sums a*conj(b) over buffer_length accepted
// beats, then presents one shifted, saturated complex result and holds it
// until the downstream block takes it.
//
// state | meaning
// ACCUM | accepting beats, counting toward buffer_length
// DRAIN | input closed, waiting for the last product to land in the accumulators
// HOLD  | result valid on out_i/out_q, waiting for m_axis_tready
module cpx_conj_mac #(
  parameter int i_bits        = 12,
  parameter int q_bits        = 12,
  parameter int buffer_length = 10,
  parameter int count_bits    = 4,
  parameter int out_bits      = 12,
  parameter int out_shift     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_axis_tvalid,
  input  logic [i_bits-1:0]   ai,
  input  logic [q_bits-1:0]   aq,
  input  logic [i_bits-1:0]   bi,
  input  logic [q_bits-1:0]   bq,
  output logic                s_axis_tready,
  output logic                s_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [out_bits-1:0] out_i,
  output logic [out_bits-1:0] out_q
);

  localparam int prod_w = i_bits + q_bits + 1;
  localparam int acc_w  = prod_w + count_bits;
  localparam logic [count_bits-1:0] last_cnt = count_bits'(buffer_length - 1);
  localparam logic signed [acc_w-1:0] sat_hi =
    {{(acc_w-out_bits+1){1'b0}}, {(out_bits-1){1'b1}}};
  localparam logic signed [acc_w-1:0] sat_lo =
    {{(acc_w-out_bits+1){1'b1}}, {(out_bits-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t                   state_q;
  logic [count_bits-1:0]    cnt_q;
  logic [1:0]               drain_q;
  logic                     tready_q;
  logic                     tvalid_q;
  logic [out_bits-1:0]      res_i_q;
  logic [out_bits-1:0]      res_q_q;

  logic                     p_valid_q;
  logic                     p_first_q;
  logic signed [prod_w-1:0] pr_q, pq_q;
  logic signed [prod_w-1:0] pr_d, pq_d;
  logic signed [acc_w-1:0]  acc_r_q, acc_q_q;
  logic signed [acc_w-1:0]  acc_r_d, acc_q_d;
  logic signed [acc_w-1:0]  pr_x, pq_x;

  logic signed [prod_w-1:0] ai_x, aq_x, bi_x, bq_x;
  logic                     accept;

  assign accept = m_axis_tvalid & tready_q;

  assign ai_x = prod_w'($signed(ai));
  assign aq_x = prod_w'($signed(aq));
  assign bi_x = prod_w'($signed(bi));
  assign bq_x = prod_w'($signed(bq));

  // Complex product with conj(b); operands widened first so nothing wraps.
  always_comb begin
    pr_d = ai_x * bi_x + aq_x * bq_x;
    pq_d = aq_x * bi_x - ai_x * bq_x;
  end

  assign pr_x = acc_w'(pr_q);
  assign pq_x = acc_w'(pq_q);

  // First product of a block reloads the accumulator so blocks never bleed together.
  always_comb begin
    acc_r_d = p_first_q ? pr_x : acc_r_q + pr_x;
    acc_q_d = p_first_q ? pq_x : acc_q_q + pq_x;
  end

  function automatic logic [out_bits-1:0] scale_sat(input logic signed [acc_w-1:0] a);
    logic signed [acc_w-1:0] v;
    v = a >>> out_shift;
    if (v > sat_hi)      return sat_hi[out_bits-1:0];
    else if (v < sat_lo) return sat_lo[out_bits-1:0];
    else                 return v[out_bits-1:0];
  endfunction

  // Stage 1: register the products of each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_first_q <= 1'b0;
      pr_q      <= '0;
      pq_q      <= '0;
    end else begin
      p_valid_q <= accept;
      if (accept) begin
        p_first_q <= (cnt_q == '0);
        pr_q      <= pr_d;
        pq_q      <= pq_d;
      end
    end
  end

  // Stage 2: accumulate registered products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r_q <= '0;
      acc_q_q <= '0;
    end else if (p_valid_q) begin
      acc_r_q <= acc_r_d;
      acc_q_q <= acc_q_d;
    end
  end

  // Sequencing FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      cnt_q    <= '0;
      drain_q  <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      res_i_q  <= '0;
      res_q_q  <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          tready_q <= 1'b1;
          if (accept) begin
            if (cnt_q == last_cnt) begin
              cnt_q    <= '0;
              drain_q  <= '0;
              tready_q <= 1'b0;
              state_q  <= DRAIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          tready_q <= 1'b0;
          if (drain_q == 2'd2) begin
            res_i_q  <= scale_sat(acc_r_q);
            res_q_q  <= scale_sat(acc_q_q);
            tvalid_q <= 1'b1;
            state_q  <= HOLD;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        HOLD: begin
          tready_q <= 1'b0;
          if (m_axis_tready) begin
            tvalid_q <= 1'b0;
            state_q  <= ACCUM;
          end
        end
        default: begin
          state_q  <= ACCUM;
          tready_q <= 1'b0;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign s_axis_tvalid = tvalid_q;
  assign out_i         = res_i_q;
  assign out_q         = res_q_q;

endmodule

// File: doc/cpx_conj_mac.md
Name: cpx_conj_mac

Overview:
- Conjugate multiply-accumulate stage that sits directly upstream of the argmax block.
- Each input beat carries one received sample a and one reference sample b.
- The block forms a·conj(b) and sums it over buffer_length beats.
- It then emits one scaled, saturated complex correlation value (out_i, out_q) per block; argmax consumes these values as its xi/xq stream.

Parameters:
- i_bits, 12, width of signed I components of a and b
- q_bits, 12, width of signed Q components of a and b
- buffer_length, 10, beats accumulated per output value (≥2)
- count_bits, 4, width of the beat counter; must hold buffer_length-1
- out_bits, 12, width of signed out_i/out_q; matches argmax i_bits/q_bits
- out_shift, 0, arithmetic right shift applied to the accumulators before saturation

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- m_axis_tvalid  input  1  input beat valid
- ai  input  i_bits  signed received I
- aq  input  q_bits  signed received Q
- bi  input  i_bits  signed reference I
- bq  input  q_bits  signed reference Q
- s_axis_tready  output  1  block accepts an input beat
- s_axis_tvalid  output  1  out_i/out_q valid
- m_axis_tready  input  1  downstream (argmax) accepts the result
- out_i  output  out_bits  signed correlation real part
- out_q  output  out_bits  signed correlation imaginary part

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst).
  - While rst is high: state=ACCUM, counter=0, accumulators=0, pipeline valids=0, s_axis_tvalid=0, out_i=out_q=0, s_axis_tready=0.
  - First edge after release: s_axis_tready=1.
  - Reset mid-block discards partial sums and any held result.
- Accept: a beat is accepted on a rising edge where m_axis_tvalid & s_axis_tready. No other input data is sampled.
- Stage 1 (registered products):
  - pr = ai*bi + aq*bq
  - pq = aq*bi − ai*bq
  - Signed, full width i_bits+q_bits+1.
- Stage 2 (accumulators):
  - acc_r/acc_q have width i_bits+q_bits+1+count_bits.
  - On the first product of a block, acc loads the product; otherwise acc += product.
  - Overflow inside the accumulator is impossible by width.
- FSM:
  - ACCUM: s_axis_tready=1. Each accept increments the counter. The accept with counter==buffer_length-1 clears the counter and moves to DRAIN; s_axis_tready is 0 from the next cycle.
  - DRAIN: s_axis_tready=0. Waits until the last product has entered acc (2 cycles). Then registers out_i/out_q and sets s_axis_tvalid=1, entering HOLD.
  - HOLD: s_axis_tready=0; s_axis_tvalid=1; out_i/out_q stable. On an edge with m_axis_tready=1, clears s_axis_tvalid and returns to ACCUM with s_axis_tready=1 next cycle.
- Latency: s_axis_tvalid rises exactly 3 clocks after the edge accepting the final beat of a block.
- Throughput: one result per buffer_length accepted beats, plus at least 4 idle input cycles.
- Output scaling:
  - v = acc >>> out_shift (arithmetic).
  - If v > 2^(out_bits-1)-1, out = 2^(out_bits-1)-1.
  - If v < −2^(out_bits-1), out = −2^(out_bits-1).
  - Otherwise out = v[out_bits-1:0].
- Gaps in m_axis_tvalid during ACCUM are allowed; a beat counts only when accepted.
- m_axis_tready is ignored outside HOLD. m_axis_tvalid is ignored outside ACCUM.

Test Plan:
- buffer_length=4, out_shift=0, out_bits=16; 4 beats a=(3,4), b=(1,0) → out_i=12, out_q=16; s_axis_tvalid high 3 clocks after 4th accept.
- Same config; 4 beats a=(0,1), b=(0,1) → (4,0). Then 4 beats a=(1,0), b=(0,1) → (0,−4). Checks conjugate sign and the back-to-back block boundary (acc reload, not carry-over).
- Saturation with out_bits=8: 4 beats a=b=(2047,0) → out_i=127, out_q=0. 4 beats a=(−2048,0), b=(2047,0) → out_i=−128.
- Backpressure: hold m_axis_tready=0 for 10 cycles after s_axis_tvalid rises.
  - Required: s_axis_tvalid stays 1, outputs unchanged, s_axis_tready=0, and beats presented with m_axis_tvalid=1 are not counted.
  - Release m_axis_tready → s_axis_tvalid falls next edge, s_axis_tready=1 the cycle after.
- Gapped input: m_axis_tvalid toggled 1,0,1,0,… for 4 accepts of a=(3,4), b=(1,0) → (12,16), identical to the contiguous case.
- Reset mid-block: accept 2 beats of a=(100,0), b=(1,0), assert rst asynchronously between edges, then 4 beats a=(3,4), b=(1,0) → (12,16). All outputs read 0 during rst.
